// File: rtl/ddr_mem_responder.sv
// DDR4-style memory responder: command decode with per-bank state, CL/CWL latency
// pipelines and fixed BL8 single-rate read/write bursts against an internal array.
module ddr_mem_responder #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CL         = 11,
    parameter int unsigned CWL        = 9
) (
    input  logic                  CK_t,
    input  logic                  reset_n,
    input  logic                  CKE,
    input  logic                  cs_n,
    input  logic                  act_n,
    input  logic                  RAS_n_A16,
    input  logic                  CAS_n_A15,
    input  logic                  WE_n_A14,
    input  logic [1:0]            bg_addr,
    input  logic [1:0]            ba_addr,
    input  logic [13:0]           row_addr,
    input  logic [9:0]            col_addr,
    input  logic                  A10_AP,
    input  logic [DATA_WIDTH-1:0] dq_in,
    output logic [DATA_WIDTH-1:0] dq_out,
    output logic                  dq_oe,
    output logic                  dqs_t_out,
    output logic                  dqs_c_out,
    output logic [15:0]           bank_open,
    output logic                  cmd_err
);

    typedef enum logic [2:0] {
        CmdMrs  = 3'b000,
        CmdRef  = 3'b001,
        CmdPre  = 3'b010,
        CmdRsvd = 3'b011,
        CmdWr   = 3'b100,
        CmdRd   = 3'b101,
        CmdZq   = 3'b110,
        CmdNop  = 3'b111
    } cmd_e;

    // Burst entry: {auto_precharge, bank[3:0], row[1:0], col[6:3]}
    localparam int unsigned EntW = 11;

    logic [15:0]           bank_act_q, bank_act_d;
    logic [13:0]           open_row_q [16];
    logic [13:0]           open_row_d [16];
    logic [2:0]            space_q, space_d;
    logic [CL-1:0]         rd_vld_q, rd_vld_d;
    logic [EntW-1:0]       rd_ent_q [CL];
    logic [EntW-1:0]       rd_ent_d [CL];
    logic [CWL-1:0]        wr_vld_q, wr_vld_d;
    logic [EntW-1:0]       wr_ent_q [CWL];
    logic [EntW-1:0]       wr_ent_d [CWL];
    logic                  rd_on_q, rd_on_d;
    logic [3:0]            rd_beat_q, rd_beat_d;
    logic [EntW-1:0]       rd_cur_q, rd_cur_d;
    logic                  wr_on_q, wr_on_d;
    logic [2:0]            wr_beat_q, wr_beat_d;
    logic [EntW-1:0]       wr_cur_q, wr_cur_d;
    logic [DATA_WIDTH-1:0] dq_out_q, dq_out_d;
    logic                  dq_oe_q, dq_oe_d;
    logic                  dqs_t_q, dqs_t_d;
    logic                  dqs_c_q, dqs_c_d;
    logic                  cmd_err_q, cmd_err_d;

    logic [DATA_WIDTH-1:0] mem_q [8192];
    logic                  mem_we;
    logic [12:0]           mem_waddr;
    logic [12:0]           rd_raddr;
    logic                  rd_fire;
    logic                  rd_close, wr_close;
    logic [15:0]           close_mask;
    logic                  rd_push, wr_push;
    logic                  cmd_vld;
    cmd_e                  cmd;
    logic [3:0]            bank;
    logic [EntW-1:0]       new_ent;
    logic                  unused_bits;

    assign cmd_vld = CKE && !cs_n;
    assign cmd     = cmd_e'({RAS_n_A16, CAS_n_A15, WE_n_A14});
    assign bank    = {bg_addr, ba_addr};
    assign new_ent = {A10_AP, bank, open_row_q[bank][1:0], col_addr[6:3]};

    always_comb begin
        unused_bits = ^{col_addr[9:7], col_addr[2:0]};
        for (int i = 0; i < 16; i++) begin
            unused_bits = unused_bits ^ (^open_row_q[i][13:2]);
        end
    end

    // Command decode and bank state
    always_comb begin
        open_row_d = open_row_q;
        cmd_err_d  = 1'b0;
        space_d    = (space_q != 3'd0) ? space_q - 3'd1 : 3'd0;
        rd_push    = 1'b0;
        wr_push    = 1'b0;
        close_mask = '0;
        if (rd_close) close_mask[rd_cur_q[9:6]] = 1'b1;
        if (wr_close) close_mask[wr_cur_q[9:6]] = 1'b1;
        bank_act_d = bank_act_q & ~close_mask;
        if (cmd_vld) begin
            if (!act_n) begin
                if (bank_act_q[bank]) begin
                    cmd_err_d = 1'b1;
                end else begin
                    bank_act_d[bank] = 1'b1;
                    open_row_d[bank] = row_addr;
                end
            end else begin
                case (cmd)
                    CmdRd, CmdWr: begin
                        // A bank auto-precharging at this edge no longer accepts bursts
                        if (!bank_act_q[bank] || close_mask[bank] || space_q != 3'd0) begin
                            cmd_err_d = 1'b1;
                        end else begin
                            space_d = 3'd7;
                            rd_push = (cmd == CmdRd);
                            wr_push = (cmd == CmdWr);
                        end
                    end
                    CmdPre: begin
                        if (A10_AP) bank_act_d = '0;
                        else        bank_act_d[bank] = 1'b0;
                    end
                    CmdRef, CmdMrs, CmdZq: cmd_err_d = |bank_act_q;
                    CmdRsvd:               cmd_err_d = 1'b1;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        rd_vld_d    = {rd_vld_q[CL-2:0], rd_push};
        rd_ent_d[0] = new_ent;
        for (int i = 1; i < CL; i++) rd_ent_d[i] = rd_ent_q[i-1];
        wr_vld_d    = {wr_vld_q[CWL-2:0], wr_push};
        wr_ent_d[0] = new_ent;
        for (int i = 1; i < CWL; i++) wr_ent_d[i] = wr_ent_q[i-1];
    end

    // Read burst: rd_beat_q==8 marks the edge after beat 7, where auto-precharge lands
    always_comb begin
        rd_on_d   = rd_on_q;
        rd_beat_d = rd_beat_q;
        rd_cur_d  = rd_cur_q;
        rd_fire   = 1'b0;
        rd_raddr  = '0;
        dq_oe_d   = 1'b0;
        dq_out_d  = '0;
        dqs_t_d   = 1'b0;
        dqs_c_d   = 1'b1;
        rd_close  = rd_on_q && (rd_beat_q == 4'd8) && rd_cur_q[10];
        if (rd_vld_q[CL-1]) begin
            rd_on_d   = 1'b1;
            rd_beat_d = 4'd1;
            rd_cur_d  = rd_ent_q[CL-1];
            rd_fire   = 1'b1;
            rd_raddr  = {rd_ent_q[CL-1][9:0], 3'd0};
        end else if (rd_on_q) begin
            if (rd_beat_q == 4'd8) begin
                rd_on_d = 1'b0;
            end else begin
                rd_fire   = 1'b1;
                rd_raddr  = {rd_cur_q[9:0], rd_beat_q[2:0]};
                rd_beat_d = rd_beat_q + 4'd1;
            end
        end
        if (rd_fire) begin
            dq_oe_d  = 1'b1;
            dq_out_d = mem_q[rd_raddr];
            dqs_t_d  = ~rd_raddr[0];
            dqs_c_d  = rd_raddr[0];
        end
    end

    always_comb begin
        wr_on_d   = wr_on_q;
        wr_beat_d = wr_beat_q;
        wr_cur_d  = wr_cur_q;
        mem_we    = 1'b0;
        mem_waddr = '0;
        wr_close  = 1'b0;
        if (wr_vld_q[CWL-1]) begin
            wr_on_d   = 1'b1;
            wr_beat_d = 3'd1;
            wr_cur_d  = wr_ent_q[CWL-1];
            mem_we    = 1'b1;
            mem_waddr = {wr_ent_q[CWL-1][9:0], 3'd0};
        end else if (wr_on_q) begin
            mem_we    = 1'b1;
            mem_waddr = {wr_cur_q[9:0], wr_beat_q};
            wr_beat_d = wr_beat_q + 3'd1;
            if (wr_beat_q == 3'd7) begin
                wr_on_d  = 1'b0;
                wr_close = wr_cur_q[10];
            end
        end
    end

    always_ff @(posedge CK_t or negedge reset_n) begin
        if (!reset_n) begin
            bank_act_q <= '0;
            for (int i = 0; i < 16; i++) open_row_q[i] <= '0;
            space_q    <= '0;
            rd_vld_q   <= '0;
            for (int i = 0; i < CL; i++) rd_ent_q[i] <= '0;
            wr_vld_q   <= '0;
            for (int i = 0; i < CWL; i++) wr_ent_q[i] <= '0;
            rd_on_q    <= 1'b0;
            rd_beat_q  <= '0;
            rd_cur_q   <= '0;
            wr_on_q    <= 1'b0;
            wr_beat_q  <= '0;
            wr_cur_q   <= '0;
            dq_out_q   <= '0;
            dq_oe_q    <= 1'b0;
            dqs_t_q    <= 1'b0;
            dqs_c_q    <= 1'b1;
            cmd_err_q  <= 1'b0;
        end else begin
            bank_act_q <= bank_act_d;
            open_row_q <= open_row_d;
            space_q    <= space_d;
            rd_vld_q   <= rd_vld_d;
            rd_ent_q   <= rd_ent_d;
            wr_vld_q   <= wr_vld_d;
            wr_ent_q   <= wr_ent_d;
            rd_on_q    <= rd_on_d;
            rd_beat_q  <= rd_beat_d;
            rd_cur_q   <= rd_cur_d;
            wr_on_q    <= wr_on_d;
            wr_beat_q  <= wr_beat_d;
            wr_cur_q   <= wr_cur_d;
            dq_out_q   <= dq_out_d;
            dq_oe_q    <= dq_oe_d;
            dqs_t_q    <= dqs_t_d;
            dqs_c_q    <= dqs_c_d;
            cmd_err_q  <= cmd_err_d;
        end
    end

    // Storage is deliberately not reset; writes stop because wr_on_q/wr_vld_q are.
    always_ff @(posedge CK_t) begin
        if (mem_we) mem_q[mem_waddr] <= dq_in;
    end

    assign dq_out    = dq_out_q;
    assign dq_oe     = dq_oe_q;
    assign dqs_t_out = dqs_t_q;
    assign dqs_c_out = dqs_c_q;
    assign bank_open = bank_act_q;
    assign cmd_err   = cmd_err_q;

endmodule
